// File: rtl/barcode_tx_if.sv
// rtl/barcode_tx_if.sv - request/line bundle between a barcode_tx user and the transmitter
//
// Purpose: groups the frame request inputs and the BC line / status outputs of
// barcode_tx so a driver and the transmitter share one port.
// Signals:
//   send        request to start a frame (single cycle, honoured only while idle)
//   station_ID  8-bit ID to transmit, latched with an accepted send
//   period      22-bit cell length in clocks, latched with an accepted send
//   BC          barcode line, idles high
//   busy        high while a frame (and guard, if built in) is in progress
//   BC_done     one-cycle pulse after the last frame cycle
// Modports: master = frame requester, slave = barcode_tx.
interface barcode_tx_if;
  logic        send;
  logic [7:0]  station_ID;
  logic [21:0] period;
  logic        BC;
  logic        busy;
  logic        BC_done;

  modport master (
    output send, station_ID, period,
    input  BC, busy, BC_done
  );

  modport slave (
    input  send, station_ID, period,
    output BC, busy, BC_done
  );
endinterface

// File: rtl/barcode_tx.sv
// rtl/barcode_tx.sv - serializes an 8-bit station ID onto the single-wire BC line
//
// Purpose: transmits one start cell followed by eight data cells (MSB first).
// Every cell is P clocks long; BC is low for the first T clocks of a cell and
// high for the rest. T = P/2 for the start cell, P/4 for a '1', 3P/4 for a '0'
// (shift truncation). P is the latched period, clamped to a minimum of 16.
// Optional build macro: BARCODE_TX_GUARD_EN adds a P-clock idle-high guard
// cell after the last data cell, still counted as busy, before BC_done.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    barcode_tx_if.slave: send/station_ID/period in, BC/busy/BC_done out
module barcode_tx (
  input  logic          clk,
  input  logic          rst_n,
  barcode_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  localparam logic [21:0] P_MIN = 22'd16;

  state_t      r_state;
  logic [21:0] r_cnt;
  logic [3:0]  r_bit;
  logic [7:0]  r_id;
  logic [21:0] r_p;
  logic        r_bc;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [21:0] w_cnt_nxt;
  logic [3:0]  w_bit_nxt;
  logic [7:0]  w_id_nxt;
  logic [21:0] w_p_nxt;
  logic        w_done_nxt;
  logic        w_busy_nxt;
  logic        w_bc_nxt;
  logic        w_cell_end;
  logic [21:0] w_half;
  logic [21:0] w_quarter;
  logic [21:0] w_t_nxt;
  logic        w_data_bit;

  // Next-state, counters and latched request.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_id_nxt    = r_id;
    w_p_nxt     = r_p;
    w_done_nxt  = 1'b0;
    w_cell_end  = (r_cnt == (r_p - 22'd1));

    case (r_state)
      S_IDLE: begin
        if (bus.send) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = 22'd0;
          w_bit_nxt   = 4'd0;
          w_id_nxt    = bus.station_ID;
          w_p_nxt     = (bus.period < P_MIN) ? P_MIN : bus.period;
        end
      end

      S_START: begin
        if (w_cell_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = 22'd0;
          w_bit_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 22'd1;
        end
      end

      S_DATA: begin
        if (w_cell_end) begin
          w_cnt_nxt = 22'd0;
          if (r_bit == 4'd7) begin
            w_bit_nxt = 4'd0;
`ifdef BARCODE_TX_GUARD_EN
            w_state_nxt = S_GUARD;
`else
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 22'd1;
        end
      end

      S_GUARD: begin
        if (w_cell_end) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 22'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 22'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 22'd0;
        w_bit_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are registered, so the low-time threshold is evaluated against
  // the values the counters will hold in the next cycle. On an accept this
  // uses the freshly clamped period, which makes BC fall on the first cycle.
  always_comb begin
    w_half     = w_p_nxt >> 1;
    w_quarter  = w_p_nxt >> 2;
    w_data_bit = w_id_nxt[3'd7 - w_bit_nxt[2:0]];
    w_t_nxt    = 22'd0;
    case (w_state_nxt)
      S_START: w_t_nxt = w_half;
      S_DATA:  w_t_nxt = w_data_bit ? w_quarter : (w_half + w_quarter);
      default: w_t_nxt = 22'd0;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_bc_nxt   = !(w_cnt_nxt < w_t_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 22'd0;
      r_bit   <= 4'd0;
      r_id    <= 8'd0;
      r_p     <= P_MIN;
      r_bc    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_id    <= w_id_nxt;
      r_p     <= w_p_nxt;
      r_bc    <= w_bc_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.BC      = r_bc;
  assign bus.busy    = r_busy;
  assign bus.BC_done = r_done;

endmodule

// File: tb/tb_barcode_tx.sv
// tb/tb_barcode_tx.sv - directed self-checking bench for barcode_tx
module tb_barcode_tx;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  barcode_tx_if bus ();

  barcode_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Requests a frame, then walks every cell measuring
  // the low run at the start of the cell. Returns at the negedge of the
  // BC_done cycle so the caller may chain a new send into that cycle.
  task automatic do_frame(input string name, input logic [7:0] id, input logic [21:0] p_in,
                          input int pe, input int ts, input int t1, input int t0,
                          input int inject);
    int n;
    int low;
    int shape_err;
    int busy_err;
    int exp_t;
    logic seen_high;
    bus.send       = 1'b1;
    bus.station_ID = id;
    bus.period     = p_in;
    @(negedge clk);
    bus.send = 1'b0;
    chk({name, " first busy"}, {31'd0, bus.busy}, 32'd1);
    chk({name, " first BC"}, {31'd0, bus.BC}, 32'd0);
    chk({name, " first done"}, {31'd0, bus.BC_done}, 32'd0);
    n = 0;
    shape_err = 0;
    busy_err = 0;
    for (int c = 0; c < 9; c++) begin
      low = 0;
      seen_high = 1'b0;
      for (int k = 0; k < pe; k++) begin
        if (bus.BC === 1'b0) begin
          low++;
          if (seen_high) shape_err++;
        end else begin
          seen_high = 1'b1;
        end
        if (bus.busy !== 1'b1 || bus.BC_done !== 1'b0) busy_err++;
        if (k == pe - 1 && bus.BC !== 1'b1) shape_err++;
        if (n == inject) begin
          bus.send       = 1'b1;
          bus.station_ID = ~id;
          bus.period     = 22'h10;
        end else if (n == inject + 1) begin
          bus.send = 1'b0;
        end
        n++;
        @(negedge clk);
      end
      if (c == 0) exp_t = ts;
      else exp_t = id[8 - c] ? t1 : t0;
      chk($sformatf("%s cell%0d low", name, c), low, exp_t);
    end
`ifdef BARCODE_TX_GUARD_EN
    for (int k = 0; k < pe; k++) begin
      if (bus.BC !== 1'b1) shape_err++;
      if (bus.busy !== 1'b1 || bus.BC_done !== 1'b0) busy_err++;
      @(negedge clk);
    end
`endif
    chk({name, " shape"}, shape_err, 32'd0);
    chk({name, " busy/done in frame"}, busy_err, 32'd0);
    chk({name, " done pulse"}, {31'd0, bus.BC_done}, 32'd1);
    chk({name, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    chk({name, " BC at done"}, {31'd0, bus.BC}, 32'd1);
  endtask

  initial begin
    int done_seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.send       = 1'b0;
    bus.station_ID = 8'h00;
    bus.period     = 22'd0;
    repeat (3) @(negedge clk);
    chk("reset BC", {31'd0, bus.BC}, 32'd1);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.BC_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ID 0x19 at P=0x200: start 0x100, '1' 0x080, '0' 0x180
    do_frame("id19", 8'h19, 22'h200, 512, 256, 128, 384, -1);
    // chained: send sampled in the BC_done cycle, P=32
    do_frame("idC5", 8'hC5, 22'h20, 32, 16, 8, 24, -1);
    @(negedge clk);
    chk("after C5 done low", {31'd0, bus.BC_done}, 32'd0);
    // P=5 clamps to 16: start 8, '1' 4, '0' 12
    do_frame("clamp", 8'h3C, 22'd5, 16, 8, 4, 12, -1);
    @(negedge clk);
    // odd P=18: start 9, '1' 4, '0' 13
    do_frame("odd18", 8'hA6, 22'd18, 18, 9, 4, 13, -1);
    @(negedge clk);
    // mid-frame request with other ID/period must be ignored
    do_frame("inject", 8'h5A, 22'h40, 64, 32, 16, 48, 100);
    @(negedge clk);
    chk("inject no restart", {31'd0, bus.busy}, 32'd0);

    // reset during data cell 3 (cell index 4) of a P=16 frame
    bus.send       = 1'b1;
    bus.station_ID = 8'hA5;
    bus.period     = 22'd16;
    @(negedge clk);
    bus.send = 1'b0;
    repeat (70) @(negedge clk);
    chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid reset BC", {31'd0, bus.BC}, 32'd1);
    chk("mid reset busy", {31'd0, bus.busy}, 32'd0);
    chk("mid reset done", {31'd0, bus.BC_done}, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (bus.BC_done !== 1'b0 || bus.busy !== 1'b0 || bus.BC !== 1'b1) done_seen++;
    end
    chk("post reset quiet", done_seen, 32'd0);
    do_frame("after rst 00", 8'h00, 22'd16, 16, 8, 4, 12, -1);
    do_frame("after rst FF", 8'hFF, 22'h20A, 522, 261, 130, 391, -1);
    @(negedge clk);
    chk("final idle", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
